// File: rtl/riscv_mult_pkg.sv
// Shared types for the iterative RISC-V multiplier: operation encoding, FSM states
// and operand-signedness helpers.
package riscv_mult_pkg;

  typedef enum logic [1:0] {
    MULT_MUL    = 2'd0,
    MULT_MULH   = 2'd1,
    MULT_MULHSU = 2'd2,
    MULT_MULHU  = 2'd3
  } mult_op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MULT   = 2'd1,
    S_SIGN   = 2'd2,
    S_RESULT = 2'd3
  } smult_state_t;

  function automatic logic op_a_signed(mult_op_t op);
    return op != MULT_MULHU;
  endfunction

  function automatic logic op_b_signed(mult_op_t op);
    return (op == MULT_MUL) || (op == MULT_MULH);
  endfunction

endpackage

// File: rtl/riscv_mult_slice.sv
// One partial product: |a| times a SLICE_W-bit slice of |b|, shifted into place
// inside the 2*XLEN accumulator frame.
module riscv_mult_slice #(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 16,
  parameter int KW      = 1
) (
  input  logic [XLEN-1:0]   a_abs_i,
  input  logic [SLICE_W-1:0] slice_i,
  input  logic [KW-1:0]     k_i,
  output logic [2*XLEN-1:0] pp_o
);

  logic [XLEN+SLICE_W-1:0] prod;

  assign prod = a_abs_i * slice_i;
  assign pp_o = (2*XLEN)'(prod) << (k_i * SLICE_W);

endmodule

// File: rtl/riscv_mult_iter.sv
// Iterative RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU), one slice of |b| per cycle.
// Optional early-out on an all-zero upper |b| is enabled by RISCV_MULT_EARLY_OUT_EN.
module riscv_mult_iter
  import riscv_mult_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 16
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            req_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            rdy_o,
  output logic [XLEN-1:0] result_o
);

  localparam int NB = XLEN / SLICE_W;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;

  generate
    if (XLEN % SLICE_W != 0) begin : g_bad_slice
      $error("riscv_mult_iter: XLEN must be a multiple of SLICE_W");
    end
  endgenerate

  smult_state_t      state_q, state_d;
  mult_op_t          op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   abs_a_q, abs_a_d;
  logic [XLEN-1:0]   abs_b_q, abs_b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [KW-1:0]     k_q, k_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              rdy_q, rdy_d;

  mult_op_t          op_in;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   abs_a_in, abs_b_in;
  logic [SLICE_W-1:0] cur_slice;
  logic [2*XLEN-1:0] pp;
  logic [2*XLEN-1:0] prod;
  logic              last_iter;

  // |x| fits in XLEN unsigned bits even for the most negative operand.
  assign op_in    = mult_op_t'(op_i);
  assign sign_a   = op_a_signed(op_in) & a_i[XLEN-1];
  assign sign_b   = op_b_signed(op_in) & b_i[XLEN-1];
  assign abs_a_in = sign_a ? (XLEN'(0) - a_i) : a_i;
  assign abs_b_in = sign_b ? (XLEN'(0) - b_i) : b_i;

  assign cur_slice = abs_b_q[k_q*SLICE_W +: SLICE_W];
  assign prod      = neg_q ? ((2*XLEN)'(0) - acc_q) : acc_q;

  riscv_mult_slice #(
    .XLEN    (XLEN),
    .SLICE_W (SLICE_W),
    .KW      (KW)
  ) u_slice (
    .a_abs_i (abs_a_q),
    .slice_i (cur_slice),
    .k_i     (k_q),
    .pp_o    (pp)
  );

`ifdef RISCV_MULT_EARLY_OUT_EN
  logic hi_zero;

  always_comb begin
    hi_zero = 1'b1;
    for (int j = 0; j < NB; j++) begin
      if ((j > int'(k_q)) && (abs_b_q[j*SLICE_W +: SLICE_W] != '0)) begin
        hi_zero = 1'b0;
      end
    end
    last_iter = (k_q == KW'(NB-1)) || hi_zero;
  end
`else
  assign last_iter = (k_q == KW'(NB-1));
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    abs_a_d  = abs_a_q;
    abs_b_d  = abs_b_q;
    acc_d    = acc_q;
    k_d      = k_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          op_d = op_in;
          if ((a_i == '0) || (b_i == '0)) begin
            result_d = '0;
            state_d  = S_RESULT;
          end else begin
            abs_a_d = abs_a_in;
            abs_b_d = abs_b_in;
            neg_d   = sign_a ^ sign_b;
            acc_d   = '0;
            k_d     = '0;
            state_d = S_MULT;
          end
        end
      end
      S_MULT: begin
        acc_d = acc_q + pp;
        k_d   = k_q + 1'b1;
        if (last_iter) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        result_d = (op_q == MULT_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        state_d  = S_RESULT;
      end
      S_RESULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush discards the operation without touching the visible result.
    if (kill_i && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end

    rdy_d = (state_d == S_RESULT);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      op_q     <= MULT_MUL;
      neg_q    <= 1'b0;
      abs_a_q  <= '0;
      abs_b_q  <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      abs_a_q  <= abs_a_d;
      abs_b_q  <= abs_b_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign rdy_o    = rdy_q;
  assign result_o = result_q;

endmodule
